pe_array_feeder: RTL

- Initiator-side sequencer that drives one pe_array_64 instance.
- Accepts a tile command (precision, bias, step count) plus a stream of act/weight beats.
- Issues the array's input protocol (core_vld, Sel_Bias, Flush, Bias, Precision), then captures the accumulated o_Psum into a result register with a valid/ready handshake.
- Sits between the act/weight buffer readers and the output writeback path.

---
 rtl/pe_array_feeder_pkg.sv | 40 ++++
 rtl/pe_feeder_done_mon.sv | 48 ++++
 rtl/pe_array_feeder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_feeder_pkg.sv
// ---------------------------------------------------------------------------
// pe_array_feeder_pkg
// Shared definitions for the pe_array_64 feeder:
//   - default beat/bias/psum widths derived from the array geometry
//   - precision code constants (2 bits per operand, packed {act, wgt})
//   - 2-bit FSM state encoding used by the feeder sequencer
// ---------------------------------------------------------------------------
package pe_array_feeder_pkg;

    // Array geometry that the default port widths are derived from
    localparam int BITS_ACT    = 8;
    localparam int BITS_WEIGHT = 8;
    localparam int PE_ROW      = 8;
    localparam int N_BIAS      = 16;
    localparam int BITS_PSUM   = 32;

    localparam int DEF_ACT_W  = BITS_ACT * PE_ROW;
    localparam int DEF_WGT_W  = BITS_WEIGHT * PE_ROW;
    localparam int DEF_BIAS_W = N_BIAS;
    localparam int DEF_PSUM_W = BITS_PSUM;

    // Per-operand precision codes
    localparam logic [1:0] P_1B = 2'b00;
    localparam logic [1:0] P_2B = 2'b01;
    localparam logic [1:0] P_4B = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_HOLD  = 2'b11
    } feeder_state_e;

    // Builds the array precision bus from the two operand codes
    function automatic logic [3:0] precCode(input logic [1:0] actPrec,
                                            input logic [1:0] wgtPrec);
        return {actPrec, wgtPrec};
    endfunction

endpackage

// File: rtl/pe_feeder_done_mon.sv
// ---------------------------------------------------------------------------
// pe_feeder_done_mon
// Watches the array's o_Done against the feeder's own Sel_Bias pulses. Every
// Sel_Bias pulse must be answered by i_Done exactly DONE_LAT cycles later;
// a missing or an unsolicited i_Done sets a sticky error flag that only
// reset clears. Only built when PE_FEEDER_DONE_CHECK_EN is defined.
//
// Ports:
//   CLK        in   clock
//   RST        in   asynchronous active-low reset
//   i_Sel_Bias in   registered Sel_Bias strobe as sent to the array
//   i_Done     in   o_Done returned by the array
//   o_Err      out  sticky protocol error
// ---------------------------------------------------------------------------
module pe_feeder_done_mon #(
    parameter int DONE_LAT = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_Sel_Bias,
    input  logic i_Done,
    output logic o_Err
);

    logic [DONE_LAT-1:0] r_pend;
    logic                r_err;
    logic [DONE_LAT:0]   w_shift;

    // Appending the new pulse at bit 0 keeps this legal for DONE_LAT == 1
    assign w_shift = {r_pend, i_Sel_Bias};

    // The oldest pending bit is the i_Done value expected this cycle;
    // any disagreement in either direction latches the error
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_shift[DONE_LAT-1:0];
            if (i_Done != r_pend[DONE_LAT-1]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_Err = r_err;

endmodule

// File: rtl/pe_array_feeder.sv
// ---------------------------------------------------------------------------
// pe_array_feeder
// Initiator-side sequencer for one pe_array_64. Accepts a tile command
// (precision, bias, step count), streams act/weight beats into the array
// with Sel_Bias on the first step and Flush on the last, waits for the
// array pipeline to drain, then presents the accumulated psum on a
// valid/ready result port. All outputs are registered.
//
// Optional build macro: PE_FEEDER_DONE_CHECK_EN enables the i_Done monitor
// (pe_feeder_done_mon) that drives o_Err; without it o_Err is tied low and
// i_Done is ignored.
//
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   i_Cmd_Vld/o_Cmd_Rdy           command handshake (ready only in IDLE)
//   i_Cmd_Len/Prec/Bias           step count (0 = 2^LEN_W), precision, bias
//   i_Data_Vld/o_Data_Rdy         act/weight beat handshake (ready in RUN)
//   i_Act, i_Weight               beat payload
//   o_Act, o_Weight, o_Precision,
//   o_Bias, o_Sel_Bias, o_Flush,
//   o_Core_Vld                    array input protocol
//   i_Psum, i_Done                array outputs
//   o_Res_Vld/i_Res_Rdy/o_Res_Data result handshake
//   o_Err                         sticky protocol error
// ---------------------------------------------------------------------------
module pe_array_feeder
    import pe_array_feeder_pkg::*;
#(
    parameter int ACT_W     = DEF_ACT_W,
    parameter int WGT_W     = DEF_WGT_W,
    parameter int BIAS_W    = DEF_BIAS_W,
    parameter int PSUM_W    = DEF_PSUM_W,
    parameter int LEN_W     = 8,
    parameter int DRAIN_LAT = 3,
    parameter int DONE_LAT  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Cmd_Vld,
    output logic              o_Cmd_Rdy,
    input  logic [LEN_W-1:0]  i_Cmd_Len,
    input  logic [3:0]        i_Cmd_Prec,
    input  logic [BIAS_W-1:0] i_Cmd_Bias,
    input  logic              i_Data_Vld,
    output logic              o_Data_Rdy,
    input  logic [ACT_W-1:0]  i_Act,
    input  logic [WGT_W-1:0]  i_Weight,
    output logic [ACT_W-1:0]  o_Act,
    output logic [WGT_W-1:0]  o_Weight,
    output logic [3:0]        o_Precision,
    output logic [BIAS_W-1:0] o_Bias,
    output logic              o_Sel_Bias,
    output logic              o_Flush,
    output logic              o_Core_Vld,
    input  logic [PSUM_W-1:0] i_Psum,
    input  logic              i_Done,
    output logic              o_Res_Vld,
    input  logic              i_Res_Rdy,
    output logic [PSUM_W-1:0] o_Res_Data,
    output logic              o_Err
);

    // One extra bit so that a length code of 0 can be loaded as 2^LEN_W
    localparam int CNT_W = LEN_W + 1;
    localparam int DRN_W = (DRAIN_LAT < 1) ? 1 : $clog2(DRAIN_LAT + 1);

    feeder_state_e r_state, w_stateNext;

    logic              r_cmdRdy,   w_cmdRdyNext;
    logic              r_dataRdy,  w_dataRdyNext;
    logic [ACT_W-1:0]  r_act,      w_actNext;
    logic [WGT_W-1:0]  r_wgt,      w_wgtNext;
    logic [3:0]        r_prec,     w_precNext;
    logic [BIAS_W-1:0] r_bias,     w_biasNext;
    logic              r_selBias,  w_selBiasNext;
    logic              r_flush,    w_flushNext;
    logic              r_coreVld,  w_coreVldNext;
    logic              r_resVld,   w_resVldNext;
    logic [PSUM_W-1:0] r_resData,  w_resDataNext;
    logic [CNT_W-1:0]  r_cnt,      w_cntNext;
    logic              r_first,    w_firstNext;
    logic [DRN_W-1:0]  r_drainCnt, w_drainCntNext;

    logic              w_cmdAcc;
    logic              w_beat;
    logic              w_lastStep;
    logic [CNT_W-1:0]  w_lenLoad;

    assign w_cmdAcc   = i_Cmd_Vld && r_cmdRdy && (r_state == ST_IDLE);
    assign w_beat     = i_Data_Vld && r_dataRdy && (r_state == ST_RUN);
    assign w_lastStep = (r_cnt == CNT_W'(1));
    assign w_lenLoad  = (i_Cmd_Len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                          : {1'b0, i_Cmd_Len};

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output logic. Strobes default low so that every
    // cycle without a beat handshake becomes a bubble toward the array.
    // Ready flags are computed one cycle ahead because they are registered.
    always_comb begin
        w_stateNext    = r_state;
        w_cmdRdyNext   = r_cmdRdy;
        w_dataRdyNext  = r_dataRdy;
        w_actNext      = r_act;
        w_wgtNext      = r_wgt;
        w_precNext     = r_prec;
        w_biasNext     = r_bias;
        w_selBiasNext  = 1'b0;
        w_flushNext    = 1'b0;
        w_coreVldNext  = 1'b0;
        w_resVldNext   = r_resVld;
        w_resDataNext  = r_resData;
        w_cntNext      = r_cnt;
        w_firstNext    = r_first;
        w_drainCntNext = r_drainCnt;

        case (r_state)
            ST_IDLE: begin
                w_cmdRdyNext = 1'b1;
                if (w_cmdAcc) begin
                    w_precNext    = i_Cmd_Prec;
                    w_biasNext    = i_Cmd_Bias;
                    w_cntNext     = w_lenLoad;
                    w_firstNext   = 1'b1;
                    w_cmdRdyNext  = 1'b0;
                    w_dataRdyNext = 1'b1;
                    w_stateNext   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (w_beat) begin
                    w_actNext     = i_Act;
                    w_wgtNext     = i_Weight;
                    w_coreVldNext = 1'b1;
                    w_selBiasNext = r_first;
                    w_flushNext   = w_lastStep;
                    w_firstNext   = 1'b0;
                    w_cntNext     = r_cnt - CNT_W'(1);
                    if (w_lastStep) begin
                        w_dataRdyNext  = 1'b0;
                        w_drainCntNext = '0;
                        w_stateNext    = ST_DRAIN;
                    end
                end
            end

            // The drain count starts on the cycle the final step is on the
            // array inputs, so the psum is sampled DRAIN_LAT cycles later
            ST_DRAIN: begin
                if (r_drainCnt == DRN_W'(DRAIN_LAT)) begin
                    w_resDataNext = i_Psum;
                    w_resVldNext  = 1'b1;
                    w_stateNext   = ST_HOLD;
                end else begin
                    w_drainCntNext = r_drainCnt + DRN_W'(1);
                end
            end

            ST_HOLD: begin
                if (i_Res_Rdy) begin
                    w_resVldNext = 1'b0;
                    w_cmdRdyNext = 1'b1;
                    w_stateNext  = ST_IDLE;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Output and datapath registers; reset discards any in-flight tile
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cmdRdy   <= 1'b1;
            r_dataRdy  <= 1'b0;
            r_act      <= '0;
            r_wgt      <= '0;
            r_prec     <= precCode(P_1B, P_1B);
            r_bias     <= '0;
            r_selBias  <= 1'b0;
            r_flush    <= 1'b0;
            r_coreVld  <= 1'b0;
            r_resVld   <= 1'b0;
            r_resData  <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_drainCnt <= '0;
        end else begin
            r_cmdRdy   <= w_cmdRdyNext;
            r_dataRdy  <= w_dataRdyNext;
            r_act      <= w_actNext;
            r_wgt      <= w_wgtNext;
            r_prec     <= w_precNext;
            r_bias     <= w_biasNext;
            r_selBias  <= w_selBiasNext;
            r_flush    <= w_flushNext;
            r_coreVld  <= w_coreVldNext;
            r_resVld   <= w_resVldNext;
            r_resData  <= w_resDataNext;
            r_cnt      <= w_cntNext;
            r_first    <= w_firstNext;
            r_drainCnt <= w_drainCntNext;
        end
    end

    assign o_Cmd_Rdy   = r_cmdRdy;
    assign o_Data_Rdy  = r_dataRdy;
    assign o_Act       = r_act;
    assign o_Weight    = r_wgt;
    assign o_Precision = r_prec;
    assign o_Bias      = r_bias;
    assign o_Sel_Bias  = r_selBias;
    assign o_Flush     = r_flush;
    assign o_Core_Vld  = r_coreVld;
    assign o_Res_Vld   = r_resVld;
    assign o_Res_Data  = r_resData;

`ifdef PE_FEEDER_DONE_CHECK_EN
    logic w_err;

    pe_feeder_done_mon #(
        .DONE_LAT (DONE_LAT)
    ) u_doneMon (
        .CLK        (CLK),
        .RST        (RST),
        .i_Sel_Bias (r_selBias),
        .i_Done     (i_Done),
        .o_Err      (w_err)
    );

    assign o_Err = w_err;
`else
    // i_Done has no consumer in this build
    logic w_unusedDone;
    assign w_unusedDone = i_Done;
    assign o_Err        = 1'b0;
`endif

endmodule
